uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (5-8 data bits, optional parity, 1/2 stop bits) feeding a first-word-fall-through character FIFO; define RX_MAJORITY_EN for 2-of-3 bit sampling
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int K_W = 19
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rx,
   input  logic [1:0]                   data_bits,
   input  logic                         pen,
   input  logic                         ohel,
   input  logic                         two_stop,
   input  logic [K_W-1:0]               k,
   input  logic                         rd,
   output logic [7:0]                   uart_rdata,
   output logic [5:0]                   rx_status,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, HOLD} state_t;
   state_t state, state_nx;
   logic rx_meta, rxs, samp, btu, commit, ferr_c, brk_c, push, pop, full, empty, ovf;
   logic par_r, perr_r, ferr_r, brk_r;
   logic [K_W-1:0] cnt, target;
   logic [2:0] bcnt, last;
   logic [7:0] sh;
   logic [10:0] mem [FIFO_DEPTH];
   logic [10:0] head;
   logic [AW-1:0] wp, rp;

   // two-flop synchroniser on the asynchronous line, idling high
   always_ff @(posedge clk)
      if (reset) {rxs, rx_meta} <= 2'b11;
      else {rxs, rx_meta} <= {rx_meta, rx};

`ifdef RX_MAJORITY_EN
   logic [1:0] hist;
   // the two previous synchronised values, voted with the current one at target
   always_ff @(posedge clk)
      if (reset) hist <= 2'b11;
      else hist <= {hist[0], rxs};
   assign samp = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
   assign samp = rxs;
`endif

   // state register
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;

   // next-state logic; a framing error parks in HOLD until the line goes high
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!rxs) state_nx = START;
         START:   if (btu) state_nx = samp ? IDLE : DATA;
         DATA:    if (btu && bcnt == last) state_nx = pen ? PARITY : STOP1;
         PARITY:  if (btu) state_nx = STOP1;
         STOP1:   if (btu) state_nx = two_stop ? STOP2 : (ferr_c ? HOLD : IDLE);
         STOP2:   if (btu) state_nx = ferr_c ? HOLD : IDLE;
         HOLD:    if (rxs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // per-state decode: bit tick, commit strobe and the final error flags of the frame
   always_comb begin
      last = {1'b0, data_bits} + 3'd4;
      target = (state == START) ? k >> 1 : k;
      btu = state != IDLE && state != HOLD && cnt == target;
      commit = btu && (state == STOP2 || (state == STOP1 && !two_stop));
      ferr_c = !samp || (state == STOP2 && ferr_r);
      brk_c = (state == STOP2) ? brk_r : (sh == 8'd0 && !(pen && par_r) && !samp);
   end

   // bit timer, LSB-first data capture and per-frame error capture
   always_ff @(posedge clk)
      if (reset || state == IDLE || state == HOLD) begin
         cnt <= '0;
         bcnt <= '0;
         sh <= '0;
         par_r <= 1'b0;
         perr_r <= 1'b0;
         ferr_r <= 1'b0;
         brk_r <= 1'b0;
      end else begin
         cnt <= btu ? '0 : cnt + 1'b1;
         if (btu && state == DATA) begin
            sh[bcnt] <= samp;
            bcnt <= bcnt + 1'b1;
         end
         if (btu && state == PARITY) begin
            par_r <= samp;
            perr_r <= samp != (^sh ^ ohel);
         end
         if (btu && state == STOP1) begin
            ferr_r <= ferr_c;
            brk_r <= brk_c;
         end
      end

   assign empty = fifo_count == '0;
   assign full = fifo_count == DEPTH_C;
   assign pop = rd && !empty;
   assign push = commit && (!full || pop);

   // character storage; no reset needed since the head is masked while empty
   always_ff @(posedge clk)
      if (push) mem[wp] <= {brk_c, ferr_c, perr_r, sh};

   // pointers, occupancy and sticky overflow, which only a real pop clears
   always_ff @(posedge clk)
      if (reset) begin
         wp <= '0;
         rp <= '0;
         fifo_count <= '0;
         ovf <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (pop) ovf <= 1'b0;
         else if (commit && full) ovf <= 1'b1;
      end

   // head entry presented combinationally, zero when empty
   always_comb begin
      head = empty ? '0 : mem[rp];
      uart_rdata = head[7:0];
      rx_status = {head[10], ovf, head[9], head[8], !empty, full};
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table plus hand sequences for latency, false start, overflow, break and reset
module tb_uart_rx_fifo;
   localparam int DEPTH = 4;
   localparam int KW = 19;
   localparam int KV = 15;
   localparam int NV = 9;
   logic clk = 1'b0, reset = 1'b1, rx = 1'b1, pen = 1'b0, ohel = 1'b0, two_stop = 1'b0, rd = 1'b0;
   logic [1:0] data_bits = 2'b11;
   logic [KW-1:0] k = KW'(KV);
   logic [7:0] uart_rdata;
   logic [5:0] rx_status;
   logic [2:0] fifo_count;
   int errors = 0, checks = 0;

   typedef struct packed {logic [7:0] d; logic brk, ferr, perr;} exp_t;
   typedef struct {
      logic [1:0] db; logic pe, oh, ts; logic [7:0] d; logic p, s1, s2;
      logic [7:0] ed; logic ebrk, eferr, eperr;
   } vec_t;
   exp_t sbq[$];
   vec_t v[NV];

   always #5 clk = ~clk;

   uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .K_W(KW)) dut (
      .clk(clk), .reset(reset), .rx(rx), .data_bits(data_bits), .pen(pen), .ohel(ohel),
      .two_stop(two_stop), .k(k), .rd(rd), .uart_rdata(uart_rdata), .rx_status(rx_status),
      .fifo_count(fifo_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (KV + 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input logic pe, input logic p,
                             input logic s1, input logic ts, input logic s2);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(d[i]);
      if (pe) send_bit(p);
      send_bit(s1);
      if (ts) send_bit(s2);
      rx = 1'b1;
   endtask

   task automatic push_exp(input logic [7:0] d, input logic brk, input logic ferr, input logic perr);
      exp_t e;
      e.d = d; e.brk = brk; e.ferr = ferr; e.perr = perr;
      sbq.push_back(e);
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      int n = 0;
      while (!rx_status[1] && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: entry present but scoreboard empty", name);
      end else begin
         e = sbq.pop_front();
         check({name, " rxrdy"}, 32'(rx_status[1]), 32'd1);
         check({name, " data"}, 32'(uart_rdata), 32'(e.d));
         check({name, " brk/ferr/perr"}, 32'({rx_status[5], rx_status[3], rx_status[2]}),
               32'({e.brk, e.ferr, e.perr}));
      end
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d;
      int n;
      exp_t e;
      v[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      v[1] = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h35, 1'b1, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0, 1'b1};
      v[2] = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h35, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0};
      v[3] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
      v[4] = '{2'b01, 1'b1, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
      v[5] = '{2'b11, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
      v[6] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};
      v[7] = '{2'b11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
      v[8] = '{2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset status", 32'(rx_status), 32'd0);
      check("reset data", 32'(uart_rdata), 32'd0);
      check("reset count", 32'(fifo_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 8N1 0xA5: entry must appear exactly 11 clocks into the stop bit
      d = 8'hA5;
      push_exp(d, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      rx = 1'b1;
      n = 0;
      while (!rx_status[1] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("commit latency", 32'(n), 32'd11);
      send_bit(1'b1);
      pop_check("latency frame");

      for (int i = 0; i < NV; i++) begin
         data_bits = v[i].db; pen = v[i].pe; ohel = v[i].oh; two_stop = v[i].ts;
         @(negedge clk);
         push_exp(v[i].ed, v[i].ebrk, v[i].eferr, v[i].eperr);
         send_frame(v[i].d, int'(v[i].db) + 5, v[i].pe, v[i].p, v[i].s1, v[i].ts, v[i].s2);
         send_bit(1'b1);
         pop_check($sformatf("vec%0d", i));
         check($sformatf("vec%0d empty status", i), 32'(rx_status), 32'd0);
         check($sformatf("vec%0d empty data", i), 32'(uart_rdata), 32'd0);
      end
      data_bits = 2'b11; pen = 1'b0; ohel = 1'b0; two_stop = 1'b0;

      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      check("rd on empty count", 32'(fifo_count), 32'd0);

      // false start: 4 low clocks, then a clean frame
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (48) @(negedge clk);
      check("false start count", 32'(fifo_count), 32'd0);
      push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      pop_check("after false start");

      // fill, then commit with simultaneous rd while full, then overflow
      for (int i = 1; i <= 4; i++) begin
         d = 8'(i * 17);
         push_exp(d, 1'b0, 1'b0, 1'b0);
         send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         send_bit(1'b1);
      end
      check("fill count", 32'(fifo_count), 32'd4);
      check("fill full", 32'(rx_status[0]), 32'd1);
      d = 8'h55;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      e = sbq.pop_front();
      check("simul head", 32'(uart_rdata), 32'(e.d));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      push_exp(d, 1'b0, 1'b0, 1'b0);
      check("simul count", 32'(fifo_count), 32'd4);
      check("simul ovf", 32'(rx_status[4]), 32'd0);
      send_bit(1'b1);
      send_frame(8'h66, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      check("drop count", 32'(fifo_count), 32'd4);
      check("drop ovf", 32'(rx_status[4]), 32'd1);
      pop_check("ovf pop1");
      check("ovf cleared", 32'(rx_status[4]), 32'd0);
      for (int i = 2; i <= 4; i++) pop_check($sformatf("ovf pop%0d", i));
      check("drained count", 32'(fifo_count), 32'd0);

      // break: line low for two frame times
      rx = 1'b0;
      repeat (320) @(negedge clk);
      check("break held count", 32'(fifo_count), 32'd1);
      rx = 1'b1;
      repeat (48) @(negedge clk);
      check("break released count", 32'(fifo_count), 32'd1);
      push_exp(8'h00, 1'b1, 1'b1, 1'b0);
      pop_check("break");

      // reset in the middle of a frame with a character already buffered
      send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      rx = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      check("midframe reset status", 32'(rx_status), 32'd0);
      check("midframe reset data", 32'(uart_rdata), 32'd0);
      check("midframe reset count", 32'(fifo_count), 32'd0);
      reset = 1'b0;
      repeat (48) @(negedge clk);
      check("post reset idle count", 32'(fifo_count), 32'd0);
      push_exp(8'hC3, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      pop_check("post reset frame");

`ifdef RX_MAJORITY_EN
      // one-clock glitch at the bit-3 sample point must be voted out
      push_exp(8'hFF, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            rx = 1'b1;
            repeat (8) @(negedge clk);
            rx = 1'b0;
            @(negedge clk);
            rx = 1'b1;
            repeat (7) @(negedge clk);
         end else send_bit(1'b1);
      end
      send_bit(1'b1);
      send_bit(1'b1);
      pop_check("glitch");
`endif

      check("scoreboard drained", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
